// File: rtl/unidade_controle_jogo_escrita_pkg.sv
// State codes, control word and output decode shared by the game control unit.
// db_estado carries these codes, so the datapath display decodes the same values.
package unidade_controle_jogo_escrita_pkg;

   localparam int TIMEOUT_CICLOS_PADRAO = 3000;
   localparam int TW_PADRAO             = 12;

   typedef enum logic [3:0] {
      INICIAL          = 4'h0,
      PREPARACAO       = 4'h1,
      INICIA_RODADA    = 4'h2,
      ESPERA_JOGADA    = 4'h3,
      REGISTRA         = 4'h4,
      COMPARACAO       = 4'h5,
      PROXIMA_JOGADA   = 4'h6,
      PROXIMO_ENDERECO = 4'h7,
      ESPERA_ESCRITA   = 4'h8,
      ESCREVE          = 4'h9,
      PROXIMA_RODADA   = 4'hA,
      FIM_ACERTOU      = 4'hB,
      FIM_ERROU        = 4'hC,
      FIM_TIMEOUT      = 4'hD
   } estado_t;

   typedef struct packed {
      logic zeraE;
      logic contaE;
      logic zeraR;
      logic contaR;
      logic zeraRegistro;
      logic registraR;
      logic escreveM;
      logic pronto;
      logic ganhou;
      logic perdeu;
      logic db_timeout;
   } controle_t;

   function automatic controle_t decodifica(input estado_t e);
      controle_t c;
      c = '0;
      case (e)
         PREPARACAO: begin
            c.zeraE        = 1'b1;
            c.zeraR        = 1'b1;
            c.zeraRegistro = 1'b1;
         end
         INICIA_RODADA:    c.zeraE     = 1'b1;
         REGISTRA:         c.registraR = 1'b1;
         PROXIMA_JOGADA:   c.contaE    = 1'b1;
         PROXIMO_ENDERECO: c.contaE    = 1'b1;
         ESCREVE: begin
            c.escreveM  = 1'b1;
            c.registraR = 1'b1;
         end
         PROXIMA_RODADA:   c.contaR    = 1'b1;
         FIM_ACERTOU: begin
            c.pronto = 1'b1;
            c.ganhou = 1'b1;
         end
         FIM_ERROU: begin
            c.pronto = 1'b1;
            c.perdeu = 1'b1;
         end
         FIM_TIMEOUT: begin
            c.pronto     = 1'b1;
            c.perdeu     = 1'b1;
            c.db_timeout = 1'b1;
         end
         default:          c = '0;
      endcase
      return c;
   endfunction

   // Only the two wait states let the inactivity counter run.
   function automatic logic em_espera(input estado_t e);
      return (e == ESPERA_JOGADA) || (e == ESPERA_ESCRITA);
   endfunction

endpackage

// File: rtl/contador_timeout.sv
// Modulo-M inactivity counter; fim flags the last count (M-1).
// zera has priority over conta; reset clears asynchronously.
module contador_timeout #(
   parameter int M = 3000,
   parameter int N = 12
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   logic [N-1:0] cnt_q;
   logic [N-1:0] cnt_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (zera) begin
         cnt_d = '0;
      end else if (conta) begin
         cnt_d = (cnt_q == N'(M - 1)) ? '0 : cnt_q + N'(1);
      end
   end

   assign fim = (cnt_q == N'(M - 1));

endmodule

// File: rtl/unidade_controle_jogo_escrita.sv
// Moore control unit of the memory-sequence game: replays rounds, records one new play per round,
// reports win/loss and times out after TIMEOUT_CICLOS idle clocks in a wait state.
module unidade_controle_jogo_escrita
   import unidade_controle_jogo_escrita_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO,
   parameter int TW             = TW_PADRAO
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       jogar,
   input  logic       jogada,
   input  logic       igual,
   input  logic       fimE,
   input  logic       fimR,
   output logic       zeraE,
   output logic       contaE,
   output logic       zeraR,
   output logic       contaR,
   output logic       zeraRegistro,
   output logic       registraR,
   output logic       escreveM,
   output logic       pronto,
   output logic       ganhou,
   output logic       perdeu,
   output logic       db_timeout,
   output logic [3:0] db_estado
);

   estado_t   state_q;
   estado_t   state_d;
   controle_t ctrl;
   logic      conta_timeout;
   logic      timeout;

   assign conta_timeout = em_espera(state_q);

   contador_timeout #(
      .M (TIMEOUT_CICLOS),
      .N (TW)
   ) u_timeout (
      .clock (clock),
      .reset (reset),
      .zera  (~conta_timeout),
      .conta (conta_timeout),
      .fim   (timeout)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= INICIAL;
      end else begin
         state_q <= state_d;
      end
   end

   // A press in the same cycle as the timeout still counts as a play.
   always_comb begin
      state_d = state_q;
      case (state_q)
         INICIAL:          if (jogar) state_d = PREPARACAO;
         PREPARACAO:       state_d = INICIA_RODADA;
         INICIA_RODADA:    state_d = ESPERA_JOGADA;
         ESPERA_JOGADA: begin
            if (jogada) begin
               state_d = REGISTRA;
            end else if (timeout) begin
               state_d = FIM_TIMEOUT;
            end
         end
         REGISTRA:         state_d = COMPARACAO;
         COMPARACAO: begin
            if (!igual) begin
               state_d = FIM_ERROU;
            end else if (!fimE) begin
               state_d = PROXIMA_JOGADA;
            end else if (fimR) begin
               state_d = FIM_ACERTOU;
            end else begin
               state_d = PROXIMO_ENDERECO;
            end
         end
         PROXIMA_JOGADA:   state_d = ESPERA_JOGADA;
         PROXIMO_ENDERECO: state_d = ESPERA_ESCRITA;
         ESPERA_ESCRITA: begin
            if (jogada) begin
               state_d = ESCREVE;
            end else if (timeout) begin
               state_d = FIM_TIMEOUT;
            end
         end
         ESCREVE:          state_d = PROXIMA_RODADA;
         PROXIMA_RODADA:   state_d = INICIA_RODADA;
         FIM_ACERTOU,
         FIM_ERROU,
         FIM_TIMEOUT:      if (jogar) state_d = PREPARACAO;
         default:          state_d = INICIAL;
      endcase
   end

   always_comb begin
      ctrl = decodifica(state_q);
   end

   assign zeraE        = ctrl.zeraE;
   assign contaE       = ctrl.contaE;
   assign zeraR        = ctrl.zeraR;
   assign contaR       = ctrl.contaR;
   assign zeraRegistro = ctrl.zeraRegistro;
   assign registraR    = ctrl.registraR;
   assign escreveM     = ctrl.escreveM;
   assign pronto       = ctrl.pronto;
   assign ganhou       = ctrl.ganhou;
   assign perdeu       = ctrl.perdeu;
   assign db_timeout   = ctrl.db_timeout;
   assign db_estado    = state_q;

endmodule

// File: tb/tb_unidade_controle_jogo_escrita.sv
// Bench for the game control unit: a behavioural datapath (counters, play register, memory)
// reacts to the controls; directed traces plus randomized whole games checked against a game-level model.
module tb_unidade_controle_jogo_escrita;

   localparam int TO = 3000;

   logic       clock = 1'b0;
   logic       reset, jogar, jogada;
   logic       igual, fimE, fimR;
   logic       zeraE, contaE, zeraR, contaR, zeraRegistro, registraR, escreveM;
   logic       pronto, ganhou, perdeu, db_timeout;
   logic [3:0] db_estado;
   logic [10:0] outs;

   int checks   = 0;
   int failures = 0;

   // behavioural datapath
   logic [3:0] e_q   = 4'd0;
   logic [3:0] r_q   = 4'd0;
   logic [3:0] reg_q = 4'd0;
   logic [3:0] botoes;
   logic [3:0] mem [16];
   int         writes = 0;

   always #5 clock = ~clock;

   unidade_controle_jogo_escrita dut (
      .clock        (clock),
      .reset        (reset),
      .jogar        (jogar),
      .jogada       (jogada),
      .igual        (igual),
      .fimE         (fimE),
      .fimR         (fimR),
      .zeraE        (zeraE),
      .contaE       (contaE),
      .zeraR        (zeraR),
      .contaR       (contaR),
      .zeraRegistro (zeraRegistro),
      .registraR    (registraR),
      .escreveM     (escreveM),
      .pronto       (pronto),
      .ganhou       (ganhou),
      .perdeu       (perdeu),
      .db_timeout   (db_timeout),
      .db_estado    (db_estado)
   );

   assign outs  = {zeraE, contaE, zeraR, contaR, zeraRegistro, registraR, escreveM,
                   pronto, ganhou, perdeu, db_timeout};
   assign igual = (reg_q == mem[e_q]);
   assign fimE  = (e_q == r_q);
   assign fimR  = (r_q == 4'd15);

   always @(posedge clock) begin
      if (zeraE) e_q <= 4'd0; else if (contaE) e_q <= e_q + 4'd1;
      if (zeraR) r_q <= 4'd0; else if (contaR) r_q <= r_q + 4'd1;
      if (zeraRegistro) reg_q <= 4'd0; else if (registraR) reg_q <= botoes;
      if (escreveM) begin
         mem[e_q] <= botoes;
         writes   <= writes + 1;
      end
   end

   // Output table of each state, taken from the state list of the game description.
   function automatic logic [10:0] spec_outs(input int st);
      case (st)
         1:  return 11'b10101000000;
         2:  return 11'b10000000000;
         4:  return 11'b00000100000;
         6:  return 11'b01000000000;
         7:  return 11'b01000000000;
         9:  return 11'b00000110000;
         10: return 11'b00010000000;
         11: return 11'b00000001100;
         12: return 11'b00000001010;
         13: return 11'b00000001011;
         default: return 11'b00000000000;
      endcase
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic press(input logic [3:0] v);
      botoes = v;
      jogada = 1'b1;
      tick();
      jogada = 1'b0;
   endtask

   task automatic wait_state(input int code, input int budget, output bit ok);
      int n = 0;
      while (db_estado !== 4'(code) && n < budget) begin
         tick();
         n++;
      end
      ok = (db_estado === 4'(code));
   endtask

   task automatic test_reset();
      reset = 1'b1; jogar = 1'b0; jogada = 1'b0; botoes = 4'd0;
      #12;
      checks++;
      if (db_estado !== 4'h0) begin failures++; $display("FAIL reset_state: got %0h want 0", db_estado); end
      checks++;
      if (outs !== 11'b0) begin failures++; $display("FAIL reset_outs: got %b want 0", outs); end
      tick();
      reset = 1'b0;
      tick(); tick();
      checks++;
      if (db_estado !== 4'h0) begin failures++; $display("FAIL idle_without_jogar: got %0h want 0", db_estado); end
   endtask

   task automatic test_start();
      int esp[$] = '{1, 2, 3};
      jogar = 1'b1;
      tick();
      jogar = 1'b0;
      foreach (esp[i]) begin
         if (i > 0) tick();
         checks++;
         if (db_estado !== 4'(esp[i]) || outs !== spec_outs(esp[i])) begin
            failures++;
            $display("FAIL start[%0d]: estado=%0h outs=%b want estado=%0h outs=%b",
                     i, db_estado, outs, esp[i], spec_outs(esp[i]));
         end
      end
   endtask

   task automatic test_round0_write();
      int esp[$] = '{4, 5, 7, 8};
      int esp2[$] = '{9, 10, 2, 3};
      press(4'd5);
      foreach (esp[i]) begin
         if (i > 0) tick();
         checks++;
         if (db_estado !== 4'(esp[i]) || outs !== spec_outs(esp[i])) begin
            failures++;
            $display("FAIL round0_replay[%0d]: estado=%0h outs=%b want estado=%0h outs=%b",
                     i, db_estado, outs, esp[i], spec_outs(esp[i]));
         end
      end
      press(4'd9);
      foreach (esp2[i]) begin
         if (i > 0) tick();
         checks++;
         if (db_estado !== 4'(esp2[i]) || outs !== spec_outs(esp2[i])) begin
            failures++;
            $display("FAIL round0_write[%0d]: estado=%0h outs=%b want estado=%0h outs=%b",
                     i, db_estado, outs, esp2[i], spec_outs(esp2[i]));
         end
      end
      checks++;
      if (mem[1] !== 4'd9 || r_q !== 4'd1) begin
         failures++;
         $display("FAIL round0_memory: mem1=%0h rodada=%0h want mem1=9 rodada=1", mem[1], r_q);
      end
   endtask

   task automatic test_error_and_restart();
      int esp[$] = '{4, 5, 6, 3};
      int esp2[$] = '{4, 5, 12};
      press(4'd5);
      foreach (esp[i]) begin
         if (i > 0) tick();
         checks++;
         if (db_estado !== 4'(esp[i]) || outs !== spec_outs(esp[i])) begin
            failures++;
            $display("FAIL round1_play0[%0d]: estado=%0h outs=%b want estado=%0h", i, db_estado, outs, esp[i]);
         end
      end
      press(4'd8);
      foreach (esp2[i]) begin
         if (i > 0) tick();
         checks++;
         if (db_estado !== 4'(esp2[i]) || outs !== spec_outs(esp2[i])) begin
            failures++;
            $display("FAIL wrong_play[%0d]: estado=%0h outs=%b want estado=%0h outs=%b",
                     i, db_estado, outs, esp2[i], spec_outs(esp2[i]));
         end
      end
      jogar = 1'b1;
      tick();
      jogar = 1'b0;
      checks++;
      if (db_estado !== 4'h1) begin failures++; $display("FAIL restart_after_loss: got %0h want 1", db_estado); end
      tick();
      checks++;
      if (db_estado !== 4'h2 || e_q !== 4'd0 || r_q !== 4'd0 || reg_q !== 4'd0) begin
         failures++;
         $display("FAIL counters_cleared: estado=%0h e=%0h r=%0h reg=%0h want 2,0,0,0", db_estado, e_q, r_q, reg_q);
      end
      tick();
   endtask

   task automatic test_timeout();
      int n;
      bit ok;
      jogar = 1'b1;
      n = 0;
      while (db_estado === 4'h3 && n < TO + 20) begin tick(); n++; end
      checks++;
      if (n != TO || db_estado !== 4'hD) begin
         failures++;
         $display("FAIL timeout_espera_jogada: clocks=%0d estado=%0h want %0d, D", n, db_estado, TO);
      end
      checks++;
      if (outs !== spec_outs(13)) begin failures++; $display("FAIL timeout_outs: got %b want %b", outs, spec_outs(13)); end
      tick();
      checks++;
      if (db_estado !== 4'h1) begin failures++; $display("FAIL jogar_held_restart: got %0h want 1", db_estado); end
      jogar = 1'b0;
      tick(); tick();
      press(4'd5);
      wait_state(8, 10, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL reach_espera_escrita: got %0h want 8", db_estado); end
      n = 0;
      while (db_estado === 4'h8 && n < TO + 20) begin tick(); n++; end
      checks++;
      if (n != TO || db_estado !== 4'hD || db_timeout !== 1'b1) begin
         failures++;
         $display("FAIL timeout_espera_escrita: clocks=%0d estado=%0h db_timeout=%b want %0d, D, 1",
                  n, db_estado, db_timeout, TO);
      end
      jogar = 1'b1; tick(); jogar = 1'b0; tick(); tick();
      repeat (TO - 1) tick();
      checks++;
      if (db_estado !== 4'h3) begin failures++; $display("FAIL still_waiting_2999: got %0h want 3", db_estado); end
      press(4'd5);
      checks++;
      if (db_estado !== 4'h4 || db_timeout !== 1'b0) begin
         failures++;
         $display("FAIL jogada_beats_timeout: estado=%0h db_timeout=%b want 4, 0", db_estado, db_timeout);
      end
   endtask

   task automatic test_reset_mid_game();
      bit ok;
      wait_state(8, 10, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL reach_8_before_reset: got %0h want 8", db_estado); end
      #3;
      reset = 1'b1;
      #1;
      checks++;
      if (db_estado !== 4'h0 || outs !== 11'b0) begin
         failures++;
         $display("FAIL async_reset: estado=%0h outs=%b want 0, 0", db_estado, outs);
      end
      tick();
      reset = 1'b0;
      tick();
      checks++;
      if (db_estado !== 4'h0 || mem[1] !== 4'd9) begin
         failures++;
         $display("FAIL after_reset: estado=%0h mem1=%0h want 0, 9", db_estado, mem[1]);
      end
   endtask

   // Player replays the remembered sequence each round and appends a random new play;
   // err_idx selects which replay (counted over the whole game) is deliberately wrong.
   task automatic test_game(input int err_idx);
      logic [3:0] seq [16];
      int  plays = 0;
      int  w0;
      int  exp_writes = 0;
      int  fim;
      int  bad = 0;
      bit  ok;
      bit  erro = 1'b0;
      w0 = writes;
      seq[0] = mem[0];
      jogar = 1'b1; tick(); jogar = 1'b0;
      for (int r = 0; r < 16 && !erro; r++) begin
         for (int i = 0; i <= r && !erro; i++) begin
            wait_state(3, 40, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL game_wait_play r=%0d i=%0d: estado=%0h want 3", r, i, db_estado); end
            repeat ($urandom_range(3)) tick();
            if (plays == err_idx) begin
               erro = 1'b1;
               press(seq[i] ^ 4'($urandom_range(15, 1)));
            end else begin
               press(seq[i]);
            end
            plays++;
         end
         if (!erro && r < 15) begin
            wait_state(8, 40, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL game_wait_write r=%0d: estado=%0h want 8", r, db_estado); end
            seq[r+1] = 4'($urandom_range(15));
            press(seq[r+1]);
            exp_writes++;
         end
      end
      fim = erro ? 12 : 11;
      wait_state(fim, 40, ok);
      checks++;
      if (!ok || outs !== spec_outs(fim)) begin
         failures++;
         $display("FAIL game_outcome err=%0d: estado=%0h outs=%b want %0h %b", err_idx, db_estado, outs, fim, spec_outs(fim));
      end
      checks++;
      if (writes - w0 != exp_writes) begin
         failures++;
         $display("FAIL game_writes err=%0d: got %0d want %0d", err_idx, writes - w0, exp_writes);
      end
      for (int k = 0; k <= exp_writes; k++) if (mem[k] !== seq[k]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL game_memory err=%0d: %0d wrong slots want 0", err_idx, bad); end
   endtask

   initial begin
      for (int k = 0; k < 16; k++) mem[k] = 4'd0;
      mem[0] = 4'd5;
      test_reset();
      test_start();
      test_round0_write();
      test_error_and_restart();
      test_timeout();
      test_reset_mid_game();
      test_game(-1);
      test_game(int'($urandom_range(135)));
      test_game(int'($urandom_range(20)));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule
